// File: rtl/fir_sched_pkg.sv
// Shared state encoding and default sizing for the multi-channel FIR scheduler.
package fir_sched_pkg;
   localparam int bW     = 8;
   localparam int hC     = 5;
   localparam int hClog2 = 3;
   localparam int nCh    = 4;
   localparam int shift  = 3;

   typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;
endpackage

// File: rtl/fir_rr_arb.sv
// Combinational round-robin arbiter; priority starts at the channel after last.
module fir_rr_arb #(
   parameter  int nCh = fir_sched_pkg::nCh,
   localparam int LW  = $clog2(nCh)
) (
   input  logic [nCh-1:0] req,
   input  logic [LW-1:0]  last,
   input  logic           en,
   output logic [nCh-1:0] gnt,
   output logic [LW-1:0]  gnt_idx,
   output logic           gnt_vld
);
   logic [LW-1:0] cand;

   // Scan from farthest to nearest so the closest requester after last wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      cand    = '0;
      for (int i = nCh; i >= 1; i--) begin
         cand = last + LW'(i);
         if (en && req[cand]) begin
            gnt       = '0;
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
            gnt_vld   = 1'b1;
         end
      end
   end
endmodule

// File: rtl/fir_chan_sched.sv
// Shares one sequential moving-sum FIR datapath among nCh round-robin requesters.
// state | meaning
// IDLE  | waiting for any in_valid; grant and accept in the same cycle
// ACC   | summing hist[cur][idx], one tap per cycle
// OUT   | holding result until out_ready
module fir_chan_sched #(
   parameter  int bW     = fir_sched_pkg::bW,
   parameter  int hC     = fir_sched_pkg::hC,
   parameter  int hClog2 = fir_sched_pkg::hClog2,
   parameter  int nCh    = fir_sched_pkg::nCh,
   parameter  int shift  = fir_sched_pkg::shift,
   localparam int CW     = $clog2(nCh),
   localparam int IW     = $clog2(hC),
   localparam int AW     = bW + hClog2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [nCh-1:0]    in_valid,
   input  logic [nCh*bW-1:0] in_data,
   output logic [nCh-1:0]    in_ready,
   output logic              out_valid,
   output logic [bW-1:0]     out_data,
   output logic [CW-1:0]     out_chan,
   input  logic              out_ready,
   output logic              busy
);
   import fir_sched_pkg::*;

   state_e        state_q, state_d;
   logic [bW-1:0] hist_q [nCh][hC];
   logic [bW-1:0] hist_d [nCh][hC];
   logic [AW-1:0] acc_q, acc_d, sum;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] cur_q, cur_d, last_q, last_d;
   logic          out_valid_q, out_valid_d, busy_q, busy_d;
   logic [bW-1:0] out_data_q, out_data_d;
   logic [CW-1:0] out_chan_q, out_chan_d;
   logic [CW-1:0] gnt_idx;
   logic          gnt_vld;

   fir_rr_arb #(.nCh(nCh)) u_arb (
      .req     (in_valid),
      .last    (last_q),
      .en      (state_q == IDLE),
      .gnt     (in_ready),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   assign sum = acc_q + AW'(hist_q[cur_q][idx_q]);

   always_comb begin
      state_d     = state_q;
      hist_d      = hist_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      cur_d       = cur_q;
      last_d      = last_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               for (int k = hC - 1; k >= 1; k--) hist_d[gnt_idx][k] = hist_q[gnt_idx][k-1];
               hist_d[gnt_idx][0] = in_data[gnt_idx*bW +: bW];
               acc_d   = '0;
               idx_d   = '0;
               cur_d   = gnt_idx;
               last_d  = gnt_idx;
               state_d = ACC;
            end
         end
         ACC: begin
            acc_d = sum;
            idx_d = idx_q + IW'(1);
            // The final tap's sum goes straight into the output register.
            if (idx_q == IW'(hC - 1)) begin
               state_d     = OUT;
               out_valid_d = 1'b1;
               out_data_d  = bW'(sum >> shift);
               out_chan_d  = cur_q;
            end
         end
         OUT: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         hist_q      <= '{default: '0};
         acc_q       <= '0;
         idx_q       <= '0;
         cur_q       <= '0;
         last_q      <= CW'(nCh - 1);
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hist_q      <= hist_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         cur_q       <= cur_d;
         last_q      <= last_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         busy_q      <= busy_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign busy      = busy_q;
endmodule
